// File: rtl/proc_pkg.sv
// Shared types and constants for the 8-bit processor control path.
package proc_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    EXECUTE   = 2'd1,
    WRITEBACK = 2'd2,
    HALT      = 2'd3
  } seq_state_t;

  localparam logic [4:0] OP_ALU_LAST = 5'd21;
  localparam logic [4:0] OP_JMP      = 5'd22;
  localparam logic [4:0] OP_BR_FIRST = 5'd23;
  localparam logic [4:0] OP_BR_LAST  = 5'd29;
  localparam logic [4:0] OP_HALT     = 5'd30;
  localparam logic [4:0] OP_SRST     = 5'd31;

  localparam int unsigned FL_L  = 0;
  localparam int unsigned FL_LE = 1;
  localparam int unsigned FL_E  = 2;
  localparam int unsigned FL_BE = 3;
  localparam int unsigned FL_B  = 4;

endpackage

// File: rtl/branch_cond.sv
// Conditional-skip decision from opcode and comparator flags; zero for non-skip opcodes.
module branch_cond
  import proc_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [4:0] flags,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_BR_FIRST: take = flags[FL_L];
      5'd24:       take = flags[FL_LE];
      5'd25:       take = flags[FL_E];
      5'd26:       take = ~flags[FL_E];
      5'd27:       take = flags[FL_BE];
      5'd28:       take = flags[FL_B];
      OP_BR_LAST:  take = flags[FL_L];
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute/writeback sequencer: owns pc, ir and the retired-instruction count.
//   state     | meaning
//   FETCH     | request imem[pc], wait for imem_ready, latch ir
//   EXECUTE   | datapath settles from ir; resolve jump / skip / halt / soft reset
//   WRITEBACK | register-bank write (lebr), pc+1, retire
//   HALT      | parked until resume, then pc+1
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 17,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [4:0]         flags,
  input  logic               resume,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    pc,
  output logic               lebr,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic               retire;
  logic [4:0]         opcode;
  logic               take;

  assign opcode = ir_q[INSTR_W-1 -: 5];

  branch_cond u_branch_cond (
    .opcode (opcode),
    .flags  (flags),
    .take   (take)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (opcode <= OP_ALU_LAST) begin
          state_d = WRITEBACK;
        end else begin
          retire  = 1'b1;
          state_d = FETCH;
          case (opcode)
            OP_JMP:  pc_d = PC_W'(ir_q[11:4]);
            OP_HALT: state_d = HALT;
            OP_SRST: pc_d = '0;
            default: pc_d = pc_q + (take ? PC_W'(2) : PC_W'(1));
          endcase
        end
      end
      WRITEBACK: begin
        pc_d    = pc_q + PC_W'(1);
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        if (resume) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    retire_cnt_d = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Outputs are decoded straight from the state flop, so lebr still shows in a reset cycle.
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign lebr       = (state_q == WRITEBACK);
  assign halted     = (state_q == HALT);
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign retire_cnt = retire_cnt_q;

endmodule
